lsu_mem_master: RTL and testbench

//  Load/store initiator driving the single-port word memory (addr/data/read_en/write_en).

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 48 ++++
 rtl/lsu_mem_master.sv | 165 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory master: access sizes, FSM states and
// the word geometry of the attached data memory.
package lsu_pkg;

    localparam int LSU_DWIDTH     = 32;
    localparam int BYTES_PER_WORD = LSU_DWIDTH / 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane datapath: extracts and extends load lanes, and merges sub-word
// store data into a previously read word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] i_word,
    input  logic [1:0]        i_lane,
    input  size_e             i_size,
    input  logic              i_unsigned,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_load,
    output logic [DWIDTH-1:0] o_merged
);

    logic [4:0]        w_shift;
    logic [DWIDTH-1:0] w_shifted;
    logic [DWIDTH-1:0] w_lane_mask;
    logic [DWIDTH-1:0] w_mask;

    assign w_shift = {i_lane, 3'b000};

    // Loads: bring the addressed lane down to bit 0, then extend from its top bit.
    always_comb begin
        w_shifted = i_word >> w_shift;
        o_load    = i_word;
        case (i_size)
            SZ_B: o_load = i_unsigned ? {{(DWIDTH-8){1'b0}}, w_shifted[7:0]}
                                      : {{(DWIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            SZ_H: o_load = i_unsigned ? {{(DWIDTH-16){1'b0}}, w_shifted[15:0]}
                                      : {{(DWIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            default: o_load = i_word;
        endcase
    end

    // Stores: bits of wdata above the access size fall outside the lane mask.
    always_comb begin
        case (i_size)
            SZ_B:    w_lane_mask = DWIDTH'(8'hFF);
            SZ_H:    w_lane_mask = DWIDTH'(16'hFFFF);
            default: w_lane_mask = '1;
        endcase
        w_mask   = w_lane_mask << w_shift;
        o_merged = (i_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a single-port word memory;
// sub-word stores are performed as read-modify-write word accesses.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int               AWIDTH     = 32,
    parameter int               DWIDTH     = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h01000000),
    parameter int               MEM_BYTES  = 1048576,
    parameter int               RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DWIDTH-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o
);

    localparam int                LANE_W   = $clog2(BYTES_PER_WORD);
    localparam logic [AWIDTH:0]   ADDR_LO  = {1'b0, BASE_ADDR};
    localparam logic [AWIDTH:0]   ADDR_END = ADDR_LO + (AWIDTH+1)'(MEM_BYTES);
    localparam logic [7:0]        RD_LAST  = 8'(RD_LATENCY - 1);

    state_e            r_state;
    logic              r_live;
    logic              r_we;
    size_e             r_size;
    logic              r_uns;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_old;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_err;
    logic [7:0]        r_cnt;

    logic              w_err;
    logic              w_accept;
    logic [DWIDTH-1:0] w_align_word;
    logic [DWIDTH-1:0] w_load;
    logic [DWIDTH-1:0] w_merged;

    // Request legality is decided combinationally so it can be registered with the request.
    always_comb begin
        w_err = 1'b0;
        case (req_size_i)
            SZ_H:    w_err = req_addr_i[0];
            SZ_W:    w_err = |req_addr_i[1:0];
            SZ_X:    w_err = 1'b1;
            default: w_err = 1'b0;
        endcase
        if ({1'b0, req_addr_i} < ADDR_LO || {1'b0, req_addr_i} >= ADDR_END) begin
            w_err = 1'b1;
        end
    end

    assign req_ready_o    = r_live && (r_state == ST_IDLE);
    assign w_accept       = req_valid_i && req_ready_o;
    assign resp_valid_o   = (r_state == ST_RESP);
    assign resp_rdata_o   = r_rdata;
    assign resp_err_o     = r_err;
    assign mem_read_en_o  = (r_state == ST_RD) || (r_state == ST_RMW_RD);
    assign mem_write_en_o = (r_state == ST_WR) || (r_state == ST_RMW_WR);
    assign mem_addr_o     = {r_addr[AWIDTH-1:LANE_W], {LANE_W{1'b0}}};
    assign w_align_word   = (r_state == ST_RMW_WR) ? r_old : mem_rdata_i;

    always_comb begin
        case (r_state)
            ST_WR:     mem_data_o = r_wdata;
            ST_RMW_WR: mem_data_o = w_merged;
            default:   mem_data_o = '0;
        endcase
    end

    lsu_lane_align #(
        .DWIDTH (DWIDTH)
    ) u_align (
        .i_word     (w_align_word),
        .i_lane     (r_addr[LANE_W-1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    // Everything resets asynchronously so enables drop the moment rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_old   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we_i;
                        r_size  <= size_e'(req_size_i);
                        r_uns   <= req_unsigned_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_rdata <= '0;
                        r_err   <= w_err;
                        r_cnt   <= '0;
                        if (w_err) begin
                            r_state <= ST_RESP;
                        end else if (!req_we_i) begin
                            r_state <= ST_RD;
                        end else if (req_size_i == SZ_W) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RMW_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_rdata <= w_load;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RMW_RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_old   <= mem_rdata_i;
                        r_state <= ST_RMW_WR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_WR:     r_state <= ST_RESP;
                ST_RMW_WR: r_state <= ST_RESP;
                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: attached word memory, byte-level reference model,
// directed scenarios and randomized load/store traffic.
module tb_lsu_mem_master;

    localparam logic [31:0] BASE = 32'h01000000;
    localparam longint      MEMB = 1048576;
    localparam int          RDL  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_rdata_i;
    logic        mem_read_en_o;
    logic        mem_write_en_o;

    int tests = 0;
    int fails = 0;
    int rd_cyc = 0;
    int wr_cyc = 0;
    int last_wait = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(
        .AWIDTH     (32),
        .DWIDTH     (32),
        .BASE_ADDR  (BASE),
        .MEM_BYTES  (1048576),
        .RD_LATENCY (RDL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_read_en_o  (mem_read_en_o),
        .mem_write_en_o (mem_write_en_o)
    );

    // 64-word memory decoding address bits [7:2]; higher bits alias.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        mem_ready = 1'b0;

    function automatic logic [31:0] init_word(int k);
        return (32'(k) * 32'h9E3779B9) ^ 32'h13572468;
    endfunction

    assign mem_rdata_i = mem[mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
            mem_ready <= 1'b1;
        end else if (mem_write_en_o) begin
            mem[mem_addr_o[7:2]] <= mem_data_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (mem_read_en_o)  rd_cyc++;
        if (mem_write_en_o) wr_cyc++;
    end

    initial begin : inv_mon
        logic        last_en;
        logic [31:0] last_addr;
        last_en   = 1'b0;
        last_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_read_en_o || mem_write_en_o) begin
                chk("en_exclusive", {31'b0, mem_read_en_o & mem_write_en_o}, 32'd0);
                if (last_en) chk("addr_stable", mem_addr_o, last_addr);
            end
            if (!mem_write_en_o) chk("data_idle_zero", mem_data_o, 32'd0);
            last_en   = mem_read_en_o || mem_write_en_o;
            last_addr = mem_addr_o;
        end
    end

    function automatic logic model_err(logic [1:0] sz, logic [31:0] a);
        longint ua;
        ua = longint'(a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && a[0]) return 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
        if (ua < longint'(BASE) || ua >= longint'(BASE) + MEMB) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] sz, logic uns, logic [1:0] lane);
        int     nb;
        longint v;
        nb = 1 << sz;
        v  = 0;
        for (int k = 0; k < nb; k++) begin
            v = v | (longint'((w >> (8 * (int'(lane) + k))) & 32'hFF) << (8 * k));
        end
        if (!uns && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(logic [31:0] w, logic [1:0] sz, logic [1:0] lane, logic [31:0] wd);
        int          nb;
        logic [31:0] r;
        nb = 1 << sz;
        r  = w;
        for (int k = 0; k < nb; k++) begin
            r[8*(int'(lane)+k) +: 8] = wd[8*k +: 8];
        end
        return r;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          input int gap, output logic [31:0] got_rd, output logic got_err);
        logic        e;
        logic [31:0] erd, hrd;
        logic        herr;
        int          elat, erc, ewc, lat, rc0, wc0, n;
        e    = model_err(sz, a);
        erd  = 32'd0;
        if (!e && !we) erd = model_load(ref_mem[a[7:2]], sz, uns, a[1:0]);
        elat = e ? 1 : (!we ? RDL + 1 : (sz == 2'd2 ? 2 : RDL + 2));
        erc  = (e || (we && sz == 2'd2)) ? 0 : RDL;
        ewc  = (e || !we) ? 0 : 1;
        got_rd  = 32'd0;
        got_err = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = a;
        req_wdata_i    = wd;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        chk("accept_ready", {31'b0, req_ready_o}, 32'd1);
        if (!req_ready_o) begin
            req_valid_i = 1'b0;
            return;
        end
        rc0 = rd_cyc;
        wc0 = wr_cyc;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        req_size_i  = 2'($urandom);
        lat = 1;
        while (!resp_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        if (!resp_valid_o) return;
        hrd  = resp_rdata_o;
        herr = resp_err_o;
        for (int h = 0; h < hold; h++) begin
            chk("hold_req_ready", {31'b0, req_ready_o}, 32'd0);
            @(negedge clk);
            chk("hold_valid", {31'b0, resp_valid_o}, 32'd1);
            chk("hold_rdata", resp_rdata_o, hrd);
            chk("hold_err", {31'b0, resp_err_o}, {31'b0, herr});
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("ready_after_hs", {31'b0, req_ready_o}, 32'd1);
        chk("valid_after_hs", {31'b0, resp_valid_o}, 32'd0);
        chk("rdata", hrd, erd);
        chk("err", {31'b0, herr}, {31'b0, e});
        chk("rd_cycles", 32'(rd_cyc - rc0), 32'(erc));
        chk("wr_cycles", 32'(wr_cyc - wc0), 32'(ewc));
        if (!e && we) ref_mem[a[7:2]] = model_store(ref_mem[a[7:2]], sz, a[1:0], wd);
        got_rd  = hrd;
        got_err = herr;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        logic        er;
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] a;
        int          wc0;
        for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready_o}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
        chk("rst_enables", {30'b0, mem_read_en_o, mem_write_en_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_resp_rdata", resp_rdata_o, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err_o}, 32'd0);
        rst = 1'b1;
        #1;
        chk("ready_at_release", {31'b0, req_ready_o}, 32'd0);
        @(negedge clk);
        chk("ready_after_release", {31'b0, req_ready_o}, 32'd1);

        // word store then load
        wc0 = wr_cyc;
        do_req(1'b1, 2'd2, 1'b0, 32'h01000004, 32'hCAFEBABE, 0, 0, rd, er);
        chk("t1_sw_one_write", 32'(wr_cyc - wc0), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h01000004, 32'd0, 0, 1, rd, er);
        chk("t1_lw_rdata", rd, 32'hCAFEBABE);
        chk("t1_lw_err", {31'b0, er}, 32'd0);

        // byte store over existing word, signed and unsigned byte loads
        do_req(1'b1, 2'd0, 1'b0, 32'h01000005, 32'hFFFFFF80, 0, 1, rd, er);
        chk("t2_sb_word", mem[1], 32'hCAFE80BE);
        do_req(1'b0, 2'd0, 1'b0, 32'h01000005, 32'd0, 0, 1, rd, er);
        chk("t2_lb", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h01000005, 32'd0, 0, 1, rd, er);
        chk("t2_lbu", rd, 32'h00000080);

        // half store, half load, misaligned half
        do_req(1'b1, 2'd1, 1'b0, 32'h01000006, 32'hABCD1234, 0, 1, rd, er);
        chk("t3_sh_word", mem[1], 32'h123480BE);
        do_req(1'b0, 2'd1, 1'b1, 32'h01000006, 32'd0, 0, 1, rd, er);
        chk("t3_lhu", rd, 32'h00001234);
        do_req(1'b0, 2'd1, 1'b0, 32'h01000005, 32'd0, 0, 1, rd, er);
        chk("t3_lh_mis_err", {31'b0, er}, 32'd1);

        // out-of-range boundaries
        do_req(1'b0, 2'd2, 1'b0, 32'h00FFFFFC, 32'd0, 0, 1, rd, er);
        chk("t4_below_err", {31'b0, er}, 32'd1);
        chk("t4_below_rdata", rd, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h01100000, 32'd0, 0, 1, rd, er);
        chk("t4_above_err", {31'b0, er}, 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h010FFFFC, 32'd0, 0, 1, rd, er);
        chk("t4_last_word_ok", {31'b0, er}, 32'd0);

        // response back-pressure, then back-to-back request
        do_req(1'b0, 2'd0, 1'b0, 32'h01000005, 32'd0, 3, 1, rd, er);
        chk("t5_held_lb", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd2, 1'b0, 32'h01000004, 32'd0, 0, 0, rd, er);
        chk("t5_b2b_accept_wait", 32'(last_wait), 32'd0);
        chk("t5_b2b_rdata", rd, 32'h123480BE);

        // reset during the read phase of a byte store
        @(negedge clk);
        wc0 = wr_cyc;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_size_i  = 2'd0;
        req_addr_i  = 32'h01000009;
        req_wdata_i = 32'h0000005A;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("t6_in_rmw_rd", {31'b0, mem_read_en_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_read_en_drop", {31'b0, mem_read_en_o}, 32'd0);
        chk("t6_write_en_low", {31'b0, mem_write_en_o}, 32'd0);
        chk("t6_resp_valid_low", {31'b0, resp_valid_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_ready_at_release", {31'b0, req_ready_o}, 32'd0);
        @(negedge clk);
        chk("t6_ready_after_release", {31'b0, req_ready_o}, 32'd1);
        chk("t6_word_unchanged", mem[2], ref_mem[2]);
        chk("t6_no_write", 32'(wr_cyc - wc0), 32'd0);

        // randomized traffic
        for (int t = 0; t < 250; t++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 15))
                0:       a = BASE - 32'($urandom_range(1, 8));
                1:       a = BASE + 32'h00100000 + 32'($urandom_range(0, 8));
                2:       a = BASE + 32'h000FFFFC + 32'($urandom_range(0, 3));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(we, sz, uns, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), rd, er);
        end

        // memory image matches the model after random traffic
        for (int k = 0; k < 64; k++) chk("final_mem", mem[k], ref_mem[k]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
